// File: rtl/reg_write_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
// WIDTH and SIZE are codebase-wide register-file constants; the FIFO entry
// struct is built from them.
package reg_write_arbiter_pkg;
  localparam int WIDTH = 32;
  localparam int SIZE  = 5;
  localparam int NREGS = 2**SIZE;

  typedef struct packed {
    logic             live;
    logic [SIZE-1:0]  rd;
    logic [WIDTH-1:0] data;
  } wb_entry_t;

  typedef enum logic {SRC_PIPE = 1'b0, SRC_AUX = 1'b1} src_e;
endpackage

// File: rtl/reg_write_fifo.sv
// Circular buffer of auxiliary writebacks. Entries can be killed in place
// (live cleared) when a newer pipe write to the same register lands.
// Popped slots are cleared to dead so live_o alone identifies outstanding work.
module reg_write_fifo
  import reg_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              push_i,
  input  wb_entry_t                         push_entry_i,
  input  logic                              pop_i,
  input  logic                              kill_i,
  input  logic [SIZE-1:0]                   kill_reg_i,
  output wb_entry_t                         head_o,
  output logic [$clog2(DEPTH):0]            count_o,
  output logic [DEPTH-1:0]                  live_o,
  output logic [DEPTH-1:0][SIZE-1:0]        rd_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]            live_q;
  logic [DEPTH-1:0][SIZE-1:0]  rd_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic [CW-1:0]               count_q;

  // Storage, pointers and count; push overrides kill on the slot it writes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live_q  <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (kill_i && rd_q[i] == kill_reg_i) live_q[i] <= 1'b0;
      if (pop_i) begin
        live_q[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + 1'b1;
      end
      if (push_i) begin
        live_q[wr_ptr] <= push_entry_i.live;
        rd_q[wr_ptr]   <= push_entry_i.rd;
        data_q[wr_ptr] <= push_entry_i.data;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = '{live: live_q[rd_ptr], rd: rd_q[rd_ptr], data: data_q[rd_ptr]};
  assign count_o = count_q;
  assign live_o  = live_q;
  assign rd_o    = rd_q;
endmodule

// File: rtl/reg_write_arbiter.sv
// Single register-file write port shared by the main pipeline (always wins)
// and a buffered auxiliary unit that drains into idle cycles. Exports a
// pending bitmap so decode can stall on registers with queued aux writes.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pipe_write_i,
  input  logic [SIZE-1:0]        pipe_register_i,
  input  logic [WIDTH-1:0]       pipe_data_i,
  input  logic                   aux_valid_i,
  input  logic [SIZE-1:0]        aux_register_i,
  input  logic [WIDTH-1:0]       aux_data_i,
  output logic                   aux_ready_o,
  output logic                   reg_write_o,
  output logic [SIZE-1:0]        write_register_o,
  output logic [WIDTH-1:0]       write_data_o,
  output logic [NREGS-1:0]       pending_o,
  output logic [$clog2(DEPTH):0] fifo_count_o
);
  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t                  head, push_entry;
  logic [DEPTH-1:0]           ent_live;
  logic [DEPTH-1:0][SIZE-1:0] ent_rd;
  logic                       pipe_act, push, pop, head_vld, issue_aux;
  src_e                       src_q;
  logic [NREGS-1:0]           pend;

  // Writes to r0 are architecturally void and never occupy the port
  assign pipe_act   = pipe_write_i && (pipe_register_i != '0);
  assign aux_ready_o = fifo_count_o < CW'(DEPTH);
  assign push       = aux_valid_i && aux_ready_o && (aux_register_i != '0);
  // Same-cycle aux result to the pipe's register is older: keep it dead
  assign push_entry = '{live: !(pipe_act && pipe_register_i == aux_register_i),
                        rd: aux_register_i, data: aux_data_i};
  assign head_vld   = fifo_count_o != '0;
  assign issue_aux  = !pipe_act && head_vld && head.live;
  // Dead heads are discarded even while the pipe owns the port
  assign pop        = head_vld && (!head.live || !pipe_act);

  reg_write_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .kill_i       (pipe_act),
    .kill_reg_i   (pipe_register_i),
    .head_o       (head),
    .count_o      (fifo_count_o),
    .live_o       (ent_live),
    .rd_o         (ent_rd)
  );

  // Registered write port; index/data hold when no write issues
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write_o      <= 1'b0;
      write_register_o <= '0;
      write_data_o     <= '0;
      src_q            <= SRC_PIPE;
    end else if (pipe_act) begin
      reg_write_o      <= 1'b1;
      write_register_o <= pipe_register_i;
      write_data_o     <= pipe_data_i;
      src_q            <= SRC_PIPE;
    end else if (issue_aux) begin
      reg_write_o      <= 1'b1;
      write_register_o <= head.rd;
      write_data_o     <= head.data;
      src_q            <= SRC_AUX;
    end else begin
      reg_write_o      <= 1'b0;
    end
  end

  // Pending = live buffered entries plus an aux write sitting in the output stage
  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_live[i]) pend[ent_rd[i]] = 1'b1;
    if (reg_write_o && src_q == SRC_AUX) pend[write_register_o] = 1'b1;
    pend[0] = 1'b0;
  end

  assign pending_o = pend;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboarded bench: stimulus queues expected register-file writes in order,
// a negedge monitor pops and compares each write the DUT issues.
module tb_reg_write_arbiter;
  import reg_write_arbiter_pkg::*;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   pipe_write_i = 1'b0;
  logic [SIZE-1:0]        pipe_register_i = '0;
  logic [WIDTH-1:0]       pipe_data_i = '0;
  logic                   aux_valid_i = 1'b0;
  logic [SIZE-1:0]        aux_register_i = '0;
  logic [WIDTH-1:0]       aux_data_i = '0;
  logic                   aux_ready_o;
  logic                   reg_write_o;
  logic [SIZE-1:0]        write_register_o;
  logic [WIDTH-1:0]       write_data_o;
  logic [NREGS-1:0]       pending_o;
  logic [$clog2(DEPTH):0] fifo_count_o;

  always #5 clk = ~clk;

  reg_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .pipe_write_i     (pipe_write_i),
    .pipe_register_i  (pipe_register_i),
    .pipe_data_i      (pipe_data_i),
    .aux_valid_i      (aux_valid_i),
    .aux_register_i   (aux_register_i),
    .aux_data_i       (aux_data_i),
    .aux_ready_o      (aux_ready_o),
    .reg_write_o      (reg_write_o),
    .write_register_o (write_register_o),
    .write_data_o     (write_data_o),
    .pending_o        (pending_o),
    .fifo_count_o     (fifo_count_o)
  );

  typedef struct {
    logic [SIZE-1:0]  r;
    logic [WIDTH-1:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input int r, input logic [WIDTH-1:0] d);
    exp_t e;
    e.r = SIZE'(r);
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      cyc();
      k++;
    end
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  // Every issued write must match the next expected write
  always @(negedge clk) begin
    if (reset && reg_write_o) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_write: got r%0d=0x%0h expected no write",
                 write_register_o, write_data_o);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_reg", 64'(write_register_o), 64'(mon_e.r));
        chk("wr_data", 64'(write_data_o), 64'(mon_e.d));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with a valid aux offer that must not be captured
    aux_valid_i = 1'b1; aux_register_i = 5'd7; aux_data_i = 32'h1;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_we",    64'(reg_write_o), 64'd0);
    chk("rst_wreg",  64'(write_register_o), 64'd0);
    chk("rst_wdata", 64'(write_data_o), 64'd0);
    chk("rst_pend",  64'(pending_o), 64'd0);
    chk("rst_count", 64'(fifo_count_o), 64'd0);
    aux_valid_i = 1'b0;
    reset = 1'b1;
    #1 chk("rst_ready", 64'(aux_ready_o), 64'd1);
    cyc();
    @(negedge clk);
    chk("rst_no_hs", 64'(fifo_count_o), 64'd0);

    // Single pipe write, 1-cycle latency
    expect_wr(5, 32'hDEADBEEF);
    pipe_write_i = 1'b1; pipe_register_i = 5'd5; pipe_data_i = 32'hDEADBEEF;
    cyc();
    pipe_write_i = 1'b0;
    @(negedge clk);
    chk("t2_we", 64'(reg_write_o), 64'd1);
    chk("t2_pend", 64'(pending_o), 64'd0);
    cyc();

    // Aux r7 buffered behind a 3-cycle pipe burst to r3
    expect_wr(3, 32'h30); expect_wr(3, 32'h31); expect_wr(3, 32'h32); expect_wr(7, 32'h11);
    pipe_write_i = 1'b1; pipe_register_i = 5'd3; pipe_data_i = 32'h30;
    aux_valid_i = 1'b1; aux_register_i = 5'd7; aux_data_i = 32'h11;
    cyc();
    aux_valid_i = 1'b0; pipe_data_i = 32'h31;
    @(negedge clk);
    chk("t3_pend_a", 64'(pending_o[7]), 64'd1);
    chk("t3_count", 64'(fifo_count_o), 64'd1);
    cyc();
    pipe_data_i = 32'h32;
    @(negedge clk);
    chk("t3_pend_b", 64'(pending_o[7]), 64'd1);
    cyc();
    pipe_write_i = 1'b0;
    @(negedge clk);
    chk("t3_pend_c", 64'(pending_o[7]), 64'd1);
    cyc();
    @(negedge clk);
    chk("t3_issue_we", 64'(reg_write_o), 64'd1);
    chk("t3_issue_reg", 64'(write_register_o), 64'd7);
    chk("t3_pend_issue", 64'(pending_o[7]), 64'd1);
    chk("t3_count_0", 64'(fifo_count_o), 64'd0);
    cyc();
    @(negedge clk);
    chk("t3_pend_clear", 64'(pending_o[7]), 64'd0);

    // Fill FIFO under an 8-cycle pipe burst; 5th offer is held back
    for (int i = 0; i < 8; i++) expect_wr(10, WIDTH'(32'h100 + i));
    for (int i = 0; i < 4; i++) expect_wr(i + 1, WIDTH'(32'hA0 + i));
    expect_wr(5, 32'hA5);
    for (int i = 0; i < 8; i++) begin
      pipe_write_i = 1'b1; pipe_register_i = 5'd10; pipe_data_i = WIDTH'(32'h100 + i);
      aux_valid_i = 1'b1;
      if (i < 4) begin
        aux_register_i = SIZE'(i + 1); aux_data_i = WIDTH'(32'hA0 + i);
      end else begin
        aux_register_i = 5'd5; aux_data_i = 32'hA5;
      end
      cyc();
      if (i == 3 || i == 7) begin
        @(negedge clk);
        chk("t4_ready_full", 64'(aux_ready_o), 64'd0);
        chk("t4_count_full", 64'(fifo_count_o), 64'd4);
      end
    end
    pipe_write_i = 1'b0;
    begin
      int  k;
      bit  got;
      k = 0; got = 1'b0;
      while (!got && k < 20) begin
        if (aux_ready_o) got = 1'b1;
        cyc();
        k++;
      end
      chk("t4_fifth_accepted", 64'(got), 64'd1);
      aux_valid_i = 1'b0;
    end
    drain("t4_drain");

    // WAW: newer pipe write to r9 kills the buffered aux value
    expect_wr(2, 32'h22); expect_wr(9, 32'hBB);
    pipe_write_i = 1'b1; pipe_register_i = 5'd2; pipe_data_i = 32'h22;
    aux_valid_i = 1'b1; aux_register_i = 5'd9; aux_data_i = 32'hAA;
    cyc();
    aux_valid_i = 1'b0; pipe_register_i = 5'd9; pipe_data_i = 32'hBB;
    @(negedge clk);
    chk("t5_pend_live", 64'(pending_o[9]), 64'd1);
    chk("t5_count_1", 64'(fifo_count_o), 64'd1);
    cyc();
    pipe_write_i = 1'b0;
    @(negedge clk);
    chk("t5_pend_killed", 64'(pending_o[9]), 64'd0);
    chk("t5_count_dead", 64'(fifo_count_o), 64'd1);
    cyc();
    @(negedge clk);
    chk("t5_dead_no_we", 64'(reg_write_o), 64'd0);
    chk("t5_count_pop", 64'(fifo_count_o), 64'd0);
    drain("t5_drain");

    // r0 on both sources: handshake completes, nothing buffered or written
    pipe_write_i = 1'b1; pipe_register_i = 5'd0; pipe_data_i = 32'h66;
    aux_valid_i = 1'b1; aux_register_i = 5'd0; aux_data_i = 32'h55;
    chk("t6_ready", 64'(aux_ready_o), 64'd1);
    cyc();
    pipe_write_i = 1'b0; aux_valid_i = 1'b0;
    @(negedge clk);
    chk("t6_count_r0", 64'(fifo_count_o), 64'd0);
    chk("t6_we_r0", 64'(reg_write_o), 64'd0);

    // Reset with 3 buffered entries discards them
    for (int i = 0; i < 3; i++) expect_wr(20, WIDTH'(32'h200 + i));
    for (int i = 0; i < 3; i++) begin
      pipe_write_i = 1'b1; pipe_register_i = 5'd20; pipe_data_i = WIDTH'(32'h200 + i);
      aux_valid_i = 1'b1; aux_register_i = SIZE'(11 + i); aux_data_i = WIDTH'(32'hB0 + i);
      cyc();
    end
    pipe_write_i = 1'b0; aux_valid_i = 1'b0;
    @(negedge clk);
    chk("t6_count_3", 64'(fifo_count_o), 64'd3);
    chk("t6_pend_3", 64'(pending_o[13:11]), 64'd7);
    #1 reset = 1'b0;
    #1;
    chk("t6_rst_we", 64'(reg_write_o), 64'd0);
    chk("t6_rst_count", 64'(fifo_count_o), 64'd0);
    chk("t6_rst_pend", 64'(pending_o), 64'd0);
    cyc();
    cyc();
    reset = 1'b1;
    repeat (4) cyc();
    @(negedge clk);
    chk("t6_post_count", 64'(fifo_count_o), 64'd0);
    drain("sb_empty");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
Write-port arbiter in front of the register file's single write port. It merges two sources:
- Main-pipeline writeback: highest priority, never stalled.
- Multi-cycle auxiliary unit (load/multiply-divide results) using a valid/ready handshake.

Auxiliary results are buffered in a small FIFO and drained into idle write-port cycles. The block exports a pending-write bitmap so decode can stall on registers with outstanding auxiliary writes.

Parameters:
WIDTH, 32, data width of a register
SIZE, 5, register index width (2**SIZE registers)
DEPTH, 4, auxiliary FIFO entries (power of two, >=2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (reset==0 resets the block)
pipe_write_i  input  1  main pipeline write enable
pipe_register_i  input  SIZE  main pipeline destination register (rd)
pipe_data_i  input  WIDTH  main pipeline write data
aux_valid_i  input  1  auxiliary result valid
aux_register_i  input  SIZE  auxiliary destination register
aux_data_i  input  WIDTH  auxiliary result data
aux_ready_o  output  1  FIFO can accept; transfer occurs when aux_valid_i && aux_ready_o
reg_write_o  output  1  to register-file write enable
write_register_o  output  SIZE  to register-file write index
write_data_o  output  WIDTH  to register-file write data
pending_o  output  2**SIZE  bit r=1: an auxiliary write to r is outstanding
fifo_count_o  output  log2(DEPTH)+1  occupied FIFO slots, live and dead

Behaviour:
- Reset (async, reset==0):
  - FIFO emptied; all entries invalid; count=0.
  - reg_write_o=0, write_register_o=0, write_data_o=0.
  - pending_o=0, fifo_count_o=0, aux_ready_o=1 one delta after release.
  - Reset mid-operation discards all buffered writes; no partial write is issued.
- Outputs reg_write_o, write_register_o and write_data_o are registered:
  - Pipe write latency is 1 cycle.
  - Aux minimum latency is 2 cycles (enqueue edge, then issue edge).
- aux_ready_o = (count < DEPTH). It is combinational from registered count only, with no path from aux_valid_i. Pops in the same cycle do not raise ready.
- FIFO entry = {live, reg, data}.
- Enqueue on handshake:
  - aux_register_i==0 → accepted but not enqueued.
  - Otherwise enqueue with live=1, except in the same-hazard case below.
- Per-cycle issue priority, evaluated on state at the start of the cycle:
  1. pipe_write_i && pipe_register_i!=0 → issue pipe write next edge.
  2. Otherwise, if the head is live → pop and issue it.
  3. Otherwise no write: reg_write_o=0; write_register_o and write_data_o hold their previous values.
- A dead head is always popped (discarded) that cycle, even during a pipe write. It never produces reg_write_o=1.
- pipe_write_i with pipe_register_i==0 is ignored entirely and counts as idle for the FIFO.
- WAW ordering: a pipe write to r≠0 clears live on every FIFO entry with reg==r (pipe data is newer).
- Same-cycle aux handshake to r while pipe writes r: the aux value is treated as older. It is accepted (handshake completes) but enqueued dead.
- Simultaneous enqueue and pop: count unchanged.
- Pointers wrap modulo DEPTH.
- pending_o[r] = OR over live FIFO entries with reg==r, OR'd with (reg_write_o && output-stage source is aux && write_register_o==r). pending_o[0] is always 0.
- The output stage carries a 1-bit source flag (pipe/aux) internally; it is reset to pipe.

Decomposition:
- Shared package: WIDTH/SIZE constants, wb_entry_t struct {live, reg[SIZE], data[WIDTH]}, source enum {SRC_PIPE, SRC_AUX}.
- Sub-module reg_write_fifo: DEPTH-entry circular buffer with push/pop, a kill_i + kill_reg_i port that clears live on matching entries, head-entry output, count, and per-entry live/reg outputs used for pending_o.
- The top level holds arbitration, the output register and pending decode.

Test Plan:
- Reset held low with aux_valid_i=1 → aux_ready_o=1 after release; all outputs 0; no handshake captured during reset.
- Single pipe write r5=0xDEADBEEF, idle FIFO → next edge reg_write_o=1, write_register_o=5, write_data_o=0xDEADBEEF; pending_o=0.
- Aux r7=0x11 accepted while pipe writes r3 for 3 consecutive cycles → pending_o[7]=1 throughout; r7 is issued on the first cycle after the pipe burst; pending_o[7]=0 the edge after issue.
- Push 4 aux (r1..r4) under a continuous pipe burst → aux_ready_o=0 at count=4; a 5th valid is held and not lost; after the burst, r1..r4 drain in order, then the 5th is accepted.
- WAW: aux r9=0xAA buffered, then pipe writes r9=0xBB → register file sees only 0xBB; dead entry popped with no write; pending_o[9]=0 the edge after the pipe write; count decrements.
- Aux r0=0x55 and pipe r0 writes → handshake completes, count stays 0, reg_write_o never asserts; assert reset mid-drain with 3 entries → count=0, reg_write_o=0 immediately.
